fifo_rd_ctrl: RTL and testbench

- Read-side controller for the dual-clock sample FIFO; runs entirely in the FIFO read-clock domain.
- Watches the FIFO empty flag, issues read-increment pulses and captures the FIFO head word.
- Presents words to the FIR sample input through a valid/ready handshake with a 2-entry output buffer.
- Marks frame boundaries and supports a flush mode that drains and discards stale FIFO contents.

---
 rtl/fifo_rd_ctrl.sv | 81 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side FIFO controller feeding a 2-entry valid/ready output buffer with framing and flush.
// Optional FIFO_RD_CTRL_DROPCNT_EN adds a saturating 16-bit oDROPCNT of discarded words.
module fifo_rd_ctrl #(
   parameter int DATAWIDTH = 8,
   parameter int CNTW      = 8
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   input  logic                 iEN,
   input  logic                 iFLUSH,
   input  logic [CNTW-1:0]      iFRMLEN,
   input  logic                 iEMPT,
   input  logic [DATAWIDTH-1:0] iRDAT,
   output logic                 oRINC,
   output logic [DATAWIDTH-1:0] oDATA,
   output logic                 oVALID,
   input  logic                 iREADY,
   output logic                 oLAST,
   output logic                 oBUSY
`ifdef FIFO_RD_CTRL_DROPCNT_EN
   ,
   output logic [15:0]          oDROPCNT
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   state_t state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [DATAWIDTH-1:0] b0_q, b0_d, b1_q, b1_d;
   logic [CNTW-1:0] beat_q, beat_d, flen_q, flen_d;
   logic push, pop;
   assign oRINC  = ~iEMPT & ((state_q == RUN & cnt_q < 2'd2) | state_q == FLUSH);
   assign push   = oRINC & state_q == RUN;
   assign oVALID = cnt_q != 2'd0;
   assign pop    = oVALID & iREADY;
   assign oDATA  = b0_q;
   assign oLAST  = oVALID & (flen_q != '0) & (beat_q == flen_q - CNTW'(1));
   assign oBUSY  = state_q != IDLE | oVALID;
   always_comb begin
      state_d = iFLUSH ? FLUSH : state_q == FLUSH ? (iEMPT ? IDLE : FLUSH) : (iEN ? RUN : IDLE);
      cnt_d   = iFLUSH ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
      // Head takes the new word when the buffer is empty or draining by one; otherwise it shifts up.
      b0_d    = (push & (cnt_q == 2'd0 | pop)) ? iRDAT : pop ? b1_q : b0_q;
      b1_d    = (push & cnt_q == 2'd1 & ~pop) ? iRDAT : b1_q;
      beat_d  = iFLUSH ? '0 : (pop & flen_q != '0) ? (oLAST ? '0 : beat_q + CNTW'(1)) : beat_q;
      flen_d  = (state_q == IDLE & iEN & ~iFLUSH) ? iFRMLEN : flen_q;
   end
`ifdef FIFO_RD_CTRL_DROPCNT_EN
   logic [15:0] drop_q, drop_d;
   logic [1:0] drop_add;
   logic [16:0] drop_sum;
   always_comb begin
      drop_add = iFLUSH ? cnt_q - 2'(pop) + 2'(oRINC) : 2'(oRINC & state_q == FLUSH);
      drop_sum = {1'b0, drop_q} + 17'(drop_add);
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end
   assign oDROPCNT = drop_q;
`endif
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         b0_q    <= '0;
         b1_q    <= '0;
         beat_q  <= '0;
         flen_q  <= '0;
`ifdef FIFO_RD_CTRL_DROPCNT_EN
         drop_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         beat_q  <= beat_d;
         flen_q  <= flen_d;
`ifdef FIFO_RD_CTRL_DROPCNT_EN
         drop_q  <= drop_d;
`endif
      end
   end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized bench with a queue-based FIFO model and an in-order scoreboard.
module tb_fifo_rd_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, en, flush, empt, ready, rinc, valid, last, busy;
   logic [7:0] frmlen, rdat, data;
`ifdef FIFO_RD_CTRL_DROPCNT_EN
   logic [15:0] dropcnt;
`endif
   int total = 0, bad = 0;
   logic [7:0] fifo[$], exp[$];
   int nb, flen_m, delivered, pops, nlast;
   logic last_r, last_v;

   fifo_rd_ctrl dut (
      .iCLK(clk), .iRST(rst), .iEN(en), .iFLUSH(flush), .iFRMLEN(frmlen),
      .iEMPT(empt), .iRDAT(rdat), .oRINC(rinc), .oDATA(data), .oVALID(valid),
      .iREADY(ready), .oLAST(last), .oBUSY(busy)
`ifdef FIFO_RD_CTRL_DROPCNT_EN
      , .oDROPCNT(dropcnt)
`endif
   );

   task automatic upd();
      empt = fifo.size() == 0;
      rdat = empt ? 8'h00 : fifo[0];
   endtask

   task automatic put(input logic [7:0] w);
      fifo.push_back(w);
      exp.push_back(w);
      upd();
   endtask

   task automatic tick();
      logic r, hs, l, el;
      logic [7:0] d, ed;
      #4;
      r = rinc; hs = valid & ready; d = data; l = last;
      last_r = r; last_v = valid;
      total++;
      if ((r & empt) !== 1'b0) begin bad++; $display("FAIL rinc_guard: oRINC=%b with iEMPT=%b", r, empt); end
      if (hs) begin
         if (exp.size() == 0) begin
            total++; bad++; $display("FAIL extra_word: got %h, expected no word", d);
         end else begin
            ed = exp.pop_front();
            el = flen_m != 0 && (nb % flen_m) == flen_m - 1;
            nb++; delivered++;
            if (l) nlast++;
            total++;
            if (d !== ed) begin bad++; $display("FAIL data: got %h expected %h", d, ed); end
            total++;
            if (l !== el) begin bad++; $display("FAIL last: beat %0d got %b expected %b", nb, l, el); end
         end
      end
      @(posedge clk); #1;
      if (r) begin void'(fifo.pop_front()); pops++; end
      upd();
   endtask

   task automatic do_reset();
      rst = 1; en = 0; flush = 0; ready = 0; frmlen = 0;
      fifo.delete(); exp.delete(); upd();
      nb = 0; flen_m = 0; delivered = 0; pops = 0; nlast = 0;
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; en = 1; flush = 0; ready = 1; frmlen = 0;
      fifo.delete(); exp.delete(); put(8'hA5);
      @(posedge clk); #1;
      total++; if (rinc !== 1'b0) begin bad++; $display("FAIL reset_rinc: got %b expected 0", rinc); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
      total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", data); end
      total++; if (last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b expected 0", last); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_stream();
      logic rr[16], vv[16];
      int f;
      do_reset();
      put(8'h11); put(8'h22); put(8'h33); put(8'h44);
      ready = 1; en = 1;
      for (int i = 0; i < 12; i++) begin tick(); rr[i] = last_r; vv[i] = last_v; end
      f = -1;
      for (int i = 11; i >= 0; i--) if (rr[i]) f = i;
      total++;
      if (f < 0 || f > 6) begin bad++; $display("FAIL stream_first_pop: index %0d expected 0..6", f); f = 0; end
      total++; if (vv[f] !== 1'b0) begin bad++; $display("FAIL stream_valid_early: got %b expected 0", vv[f]); end
      for (int k = 0; k < 5; k++) begin
         total++;
         if (rr[f+k] !== (k < 4)) begin bad++; $display("FAIL stream_rinc[%0d]: got %b expected %b", k, rr[f+k], k < 4); end
         total++;
         if (vv[f+1+k] !== (k < 4)) begin bad++; $display("FAIL stream_valid[%0d]: got %b expected %b", k, vv[f+1+k], k < 4); end
      end
      total++; if (delivered !== 4) begin bad++; $display("FAIL stream_count: got %0d expected 4", delivered); end
   endtask

   task automatic test_backpressure();
      logic [7:0] first;
      do_reset();
      first = 8'($urandom);
      put(first);
      for (int i = 0; i < 4; i++) put(8'($urandom));
      ready = 0; en = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i >= 3) begin
            total++;
            if (data !== first || valid !== 1'b1) begin bad++; $display("FAIL bp_hold: got %h/%b expected %h/1", data, valid, first); end
         end
      end
      total++; if (pops !== 2) begin bad++; $display("FAIL bp_pops: got %0d expected 2", pops); end
      ready = 1;
      for (int i = 0; i < 12; i++) tick();
      total++; if (delivered !== 5) begin bad++; $display("FAIL bp_count: got %0d expected 5", delivered); end
      total++; if (exp.size() !== 0) begin bad++; $display("FAIL bp_left: got %0d expected 0", exp.size()); end
   endtask

   task automatic test_frame();
      do_reset();
      frmlen = 8'd3; flen_m = 3; ready = 1;
      for (int i = 0; i < 7; i++) put(8'(8'h70 + i));
      en = 1;
      for (int i = 0; i < 14; i++) tick();
      total++; if (delivered !== 7) begin bad++; $display("FAIL frame_count: got %0d expected 7", delivered); end
      total++; if (nlast !== 2) begin bad++; $display("FAIL frame_lasts: got %0d expected 2", nlast); end
   endtask

   task automatic test_flush();
      logic rr[16];
      do_reset();
      ready = 0;
      for (int i = 0; i < 8; i++) put(8'($urandom));
      en = 1;
      for (int i = 0; i < 5; i++) tick();
      total++; if (pops !== 2) begin bad++; $display("FAIL flush_prebuf: got %0d pops expected 2", pops); end
      flush = 1; en = 0;
      tick();
      flush = 0;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b expected 0", valid); end
      for (int i = 0; i < 10; i++) begin tick(); rr[i] = last_r; end
      for (int k = 0; k < 10; k++) begin
         total++;
         if (rr[k] !== (k < 6)) begin bad++; $display("FAIL flush_rinc[%0d]: got %b expected %b", k, rr[k], k < 6); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle: busy=%b expected 0", busy); end
`ifdef FIFO_RD_CTRL_DROPCNT_EN
      total++; if (dropcnt !== 16'd8) begin bad++; $display("FAIL flush_dropcnt: got %0d expected 8", dropcnt); end
`endif
      exp.delete(); nb = 0; delivered = 0;
      put(8'hC1); put(8'hC2);
      ready = 1; en = 1;
      for (int i = 0; i < 6; i++) tick();
      total++; if (delivered !== 2) begin bad++; $display("FAIL flush_recover: got %0d expected 2", delivered); end
   endtask

   task automatic test_random();
      int nput;
      do_reset();
      frmlen = 8'($urandom_range(0, 4)); flen_m = int'(frmlen);
      nput = 0;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 2) == 0) begin put(8'($urandom)); nput++; end
         ready = 1'($urandom_range(0, 1));
         en = $urandom_range(0, 9) != 0;
         tick();
      end
      ready = 1; en = 1;
      for (int i = 0; i < 40; i++) tick();
      total++; if (exp.size() !== 0) begin bad++; $display("FAIL rand_left: got %0d expected 0", exp.size()); end
      total++; if (delivered !== nput) begin bad++; $display("FAIL rand_count: got %0d expected %0d", delivered, nput); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_frame();
      test_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
